// File: rtl/voq_rr_scheduler_if.sv
// rtl/voq_rr_scheduler_if.sv - FIFO read port and output stage bundle for the VOQ scheduler
interface voq_rr_scheduler_if #(
    parameter int PORT_NUB = 4,
    parameter int DEPTH    = 100
);
    localparam int WIDTH_ADDR = $clog2(DEPTH);
    localparam int WIDTH_SEL  = $clog2(PORT_NUB);

    logic [PORT_NUB-1:0]   fifo_empty;
    logic [WIDTH_ADDR-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic [WIDTH_SEL-1:0]  fifo_rd_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH_ADDR-1:0] out_addr;
    logic [WIDTH_SEL-1:0]  out_port;

    // scheduler side
    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, fifo_rd_sel, out_valid, out_addr, out_port
    );

    // FIFO and consumer side
    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, fifo_rd_sel, out_valid, out_addr, out_port
    );
endinterface

// File: rtl/voq_rr_scheduler.sv
// rtl/voq_rr_scheduler.sv - round-robin burst read scheduler for the shared multi-channel address FIFO
module voq_rr_scheduler #(
    parameter int PORT_NUB  = 4,
    parameter int DEPTH     = 100,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sched_en,
    input  logic [PORT_NUB-1:0] port_mask,
    voq_rr_scheduler_if.master  bus,
    output logic                busy
);
    localparam int WIDTH_ADDR  = $clog2(DEPTH);
    localparam int WIDTH_SEL   = $clog2(PORT_NUB);
    localparam int WIDTH_BURST = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t                 state;
    logic [WIDTH_SEL-1:0]   rr_ptr;
    logic [WIDTH_SEL-1:0]   grant;
    logic [WIDTH_BURST-1:0] burst_cnt;
    logic                   valid_q;
    logic [WIDTH_ADDR-1:0]  addr_q;
    logic [WIDTH_SEL-1:0]   port_q;

    logic [PORT_NUB-1:0]    eligible;
    logic                   can_issue;
    logic                   arb_found;
    logic [WIDTH_SEL-1:0]   arb_sel;
    logic                   pop;
    logic [WIDTH_SEL-1:0]   rd_sel;

    // channel index after c, wrapping at PORT_NUB (which need not be a power of 2)
    function automatic logic [WIDTH_SEL-1:0] next_ch(input logic [WIDTH_SEL-1:0] c);
        return (c == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : c + WIDTH_SEL'(1);
    endfunction

    assign eligible  = ~bus.fifo_empty & port_mask;
    assign can_issue = sched_en & (~valid_q | bus.out_ready);

    // first eligible channel scanning upward from rr_ptr; descending loop lets the nearest one win
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= PORT_NUB) begin
                idx = idx - PORT_NUB;
            end
            if (eligible[WIDTH_SEL'(idx)]) begin
                arb_found = 1'b1;
                arb_sel   = WIDTH_SEL'(idx);
            end
        end
    end

    // pop decision: arbitration result while idle, the granted channel while serving
    always_comb begin
        pop    = 1'b0;
        rd_sel = grant;
        if (state == IDLE) begin
            pop    = can_issue & arb_found;
            rd_sel = arb_sel;
        end else begin
            pop    = can_issue & eligible[grant];
        end
    end

    assign bus.fifo_rd_en  = pop & rst_n;
    assign bus.fifo_rd_sel = rd_sel;
    assign bus.out_valid   = valid_q;
    assign bus.out_addr    = addr_q;
    assign bus.out_port    = port_q;
    assign busy            = (state == SERVE) | valid_q;

    // grant FSM plus the registered output stage; a stalled entry blocks pops so it stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            port_q    <= '0;
        end else begin
            if (pop) begin
                valid_q <= 1'b1;
                addr_q  <= bus.fifo_rd_data;
                port_q  <= rd_sel;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        grant     <= arb_sel;
                        burst_cnt <= WIDTH_BURST'(1);
                        if (MAX_BURST > 1) begin
                            state <= SERVE;
                        end else begin
                            rr_ptr <= next_ch(arb_sel);
                        end
                    end
                end
                SERVE: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + WIDTH_BURST'(1);
                        if ((burst_cnt + WIDTH_BURST'(1)) == WIDTH_BURST'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= next_ch(grant);
                        end
                    end else if (!eligible[grant] || !sched_en) begin
                        state  <= IDLE;
                        rr_ptr <= next_ch(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voq_rr_scheduler.sv
// tb/tb_voq_rr_scheduler.sv - self-checking bench for voq_rr_scheduler
module tb_voq_rr_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sched_en;
    logic [3:0] port_mask;
    logic       busy4;
    logic       busy1;

    always #5 clk = ~clk;

    voq_rr_scheduler_if #(.PORT_NUB(4), .DEPTH(100)) if4 ();
    voq_rr_scheduler_if #(.PORT_NUB(4), .DEPTH(100)) if1 ();

    voq_rr_scheduler #(.PORT_NUB(4), .DEPTH(100), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .port_mask(port_mask),
        .bus(if4), .busy(busy4)
    );

    voq_rr_scheduler #(.PORT_NUB(4), .DEPTH(100), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .port_mask(port_mask),
        .bus(if1), .busy(busy1)
    );

    logic [6:0] mem [2][4][256];
    int         load_cnt [2][4] = '{default: 0};
    int         pop_cnt  [2][4] = '{default: 0};
    logic [6:0] mq [4][$];
    int         checks = 0;
    int         errors = 0;

    bit   [8:0] t1_en = 9'b011111011;
    logic [1:0] t1_sel [9] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

    // FIFO model presentation: registered empty flags, combinational head of the selected channel
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            if4.fifo_empty[c] = (load_cnt[0][c] == pop_cnt[0][c]);
            if1.fifo_empty[c] = (load_cnt[1][c] == pop_cnt[1][c]);
        end
        if4.fifo_rd_data = mem[0][if4.fifo_rd_sel][8'(pop_cnt[0][if4.fifo_rd_sel])];
        if1.fifo_rd_data = mem[1][if1.fifo_rd_sel][8'(pop_cnt[1][if1.fifo_rd_sel])];
    end

    // FIFO model pop side
    always @(posedge clk) begin
        if (if4.fifo_rd_en) pop_cnt[0][if4.fifo_rd_sel] <= pop_cnt[0][if4.fifo_rd_sel] + 1;
        if (if1.fifo_rd_en) pop_cnt[1][if1.fifo_rd_sel] <= pop_cnt[1][if1.fifo_rd_sel] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input int k, input logic en, input logic [1:0] sel);
        logic       e;
        logic [1:0] s;
        e = (k == 0) ? if4.fifo_rd_en  : if1.fifo_rd_en;
        s = (k == 0) ? if4.fifo_rd_sel : if1.fifo_rd_sel;
        chk({tag, "_rd_en"}, 32'(e), 32'(en));
        if (en) chk({tag, "_rd_sel"}, 32'(s), 32'(sel));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        sched_en      = 1'b0;
        port_mask     = 4'hF;
        if4.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) load_cnt[k][c] = pop_cnt[k][c];
        for (int c = 0; c < 4; c++) mq[c].delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int k, input int c, input int n);
        logic [6:0] d;
        for (int j = 0; j < n; j++) begin
            d = 7'($urandom);
            mem[k][c][8'(load_cnt[k][c])] = d;
            load_cnt[k][c] = load_cnt[k][c] + 1;
            mq[c].push_back(d);
        end
    endtask

    // reference order: from channel 0, serve the next non-empty queue for min(burst, size) entries
    task automatic drain(input int k, input int mb, input int pct, input string tag);
        logic [1:0] exp_p[$];
        logic [6:0] exp_a[$];
        int         ptr, found, n, got, cyc;
        logic       r, v;
        logic [1:0] p;
        logic [6:0] a;
        ptr = 0;
        forever begin
            found = -1;
            for (int s = 0; s < 4; s++) begin
                if (found < 0 && mq[(ptr + s) % 4].size() > 0) found = (ptr + s) % 4;
            end
            if (found < 0) break;
            n = (mq[found].size() < mb) ? mq[found].size() : mb;
            for (int j = 0; j < n; j++) begin
                exp_p.push_back(2'(found));
                exp_a.push_back(mq[found].pop_front());
            end
            ptr = (found + 1) % 4;
        end
        sched_en = 1'b1;
        got = 0;
        cyc = 0;
        while (got < exp_p.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            r = ($urandom_range(99) < pct);
            if (k == 0) if4.out_ready = r; else if1.out_ready = r;
            #1;
            v = (k == 0) ? if4.out_valid : if1.out_valid;
            p = (k == 0) ? if4.out_port  : if1.out_port;
            a = (k == 0) ? if4.out_addr  : if1.out_addr;
            if (v && r) begin
                chk({tag, "_port"}, 32'(p), 32'(exp_p[got]));
                chk({tag, "_addr"}, 32'(a), 32'(exp_a[got]));
                got++;
            end
        end
        chk({tag, "_count"}, 32'(got), 32'(exp_p.size()));
        if4.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_idle_busy"}, 32'((k == 0) ? busy4 : busy1), 32'(0));
    endtask

    initial begin
        logic [6:0] a0;
        rst_n         = 1'b0;
        sched_en      = 1'b0;
        port_mask     = 4'hF;
        if4.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(if4.out_valid), 32'(0));
        chk("rst_addr",  32'(if4.out_addr),  32'(0));
        chk("rst_port",  32'(if4.out_port),  32'(0));
        chk("rst_rd_en", 32'(if4.fifo_rd_en), 32'(0));
        chk("rst_busy4", 32'(busy4), 32'(0));
        chk("rst_busy1", 32'(busy1), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 short, ch2 long: bubble after ch0 empties, ch2 re-granted without bubble
        do_reset();
        load(0, 0, 2);
        load(0, 2, 5);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) sched_en = 1'b1;
            #1;
            chk_pop("t1", 0, t1_en[i], t1_sel[i]);
            if (i > 0) begin
                chk("t1_valid", 32'(if4.out_valid), 32'(t1_en[i-1]));
                if (t1_en[i-1]) chk("t1_port", 32'(if4.out_port), 32'(t1_sel[i-1]));
            end
        end

        // backpressure mid-burst holds the entry and the burst count
        do_reset();
        load(0, 1, 6);
        load(0, 3, 2);
        if4.out_ready = 1'b0;
        @(negedge clk);
        sched_en = 1'b1;
        #1;
        chk_pop("t2_first", 0, 1'b1, 2'd1);
        a0 = mq[1][0];
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_pop("t2_stall", 0, 1'b0, 2'd0);
            chk("t2_valid", 32'(if4.out_valid), 32'(1));
            chk("t2_addr",  32'(if4.out_addr),  32'(a0));
            chk("t2_port",  32'(if4.out_port),  32'(1));
        end
        drain(0, 4, 100, "t2");

        // burst of one: strict rotation, one pop per cycle
        do_reset();
        for (int c = 0; c < 4; c++) load(1, c, 3);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) sched_en = 1'b1;
            #1;
            chk_pop("t3", 1, (i < 12), 2'(i % 4));
            if (i > 0) chk("t3_port", 32'(if1.out_port), 32'((i - 1) % 4));
        end

        // granted channel masked off mid-burst
        do_reset();
        load(0, 1, 5);
        load(0, 2, 2);
        @(negedge clk);
        sched_en = 1'b1;
        #1;
        chk_pop("t4_p1", 0, 1'b1, 2'd1);
        @(negedge clk);
        #1;
        chk_pop("t4_p2", 0, 1'b1, 2'd1);
        @(negedge clk);
        port_mask = 4'b1101;
        #1;
        chk_pop("t4_release", 0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        chk_pop("t4_ch2a", 0, 1'b1, 2'd2);
        @(negedge clk);
        #1;
        chk_pop("t4_ch2b", 0, 1'b1, 2'd2);
        @(negedge clk);
        #1;
        chk_pop("t4_empty", 0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        chk_pop("t4_masked", 0, 1'b0, 2'd0);
        chk("t4_busy", 32'(busy4), 32'(0));
        @(negedge clk);
        port_mask = 4'hF;
        #1;
        chk_pop("t4_unmask", 0, 1'b1, 2'd1);
        void'(mq[1].pop_front());
        void'(mq[1].pop_front());
        void'(mq[2].pop_front());
        void'(mq[2].pop_front());
        drain(0, 4, 100, "t4");

        // enable dropped mid-burst with a stalled entry
        do_reset();
        load(0, 0, 4);
        if4.out_ready = 1'b0;
        @(negedge clk);
        sched_en = 1'b1;
        #1;
        chk_pop("t5_first", 0, 1'b1, 2'd0);
        @(negedge clk);
        sched_en = 1'b0;
        #1;
        chk_pop("t5_off", 0, 1'b0, 2'd0);
        chk("t5_busy_a", 32'(busy4), 32'(1));
        @(negedge clk);
        #1;
        chk_pop("t5_off2", 0, 1'b0, 2'd0);
        chk("t5_valid", 32'(if4.out_valid), 32'(1));
        if4.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_drained", 32'(if4.out_valid), 32'(0));
        chk("t5_busy_b", 32'(busy4), 32'(0));
        chk_pop("t5_none", 0, 1'b0, 2'd0);

        // reset mid-burst discards the pending entry
        do_reset();
        load(0, 1, 2);
        load(0, 3, 3);
        @(negedge clk);
        sched_en = 1'b1;
        #1;
        chk_pop("t6_first", 0, 1'b1, 2'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(if4.out_valid), 32'(0));
        chk("t6_rd_en", 32'(if4.fifo_rd_en), 32'(0));
        chk("t6_busy",  32'(busy4), 32'(0));
        chk("t6_port",  32'(if4.out_port), 32'(0));
        chk("t6_addr",  32'(if4.out_addr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_pop("t6_after", 0, 1'b1, 2'd1);
        void'(mq[1].pop_front());
        drain(0, 4, 100, "t6");

        // random queue contents with random consumer stalls
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 4; c++) load((r < 5) ? 0 : 1, c, int'($urandom_range(9)));
            drain((r < 5) ? 0 : 1, (r < 5) ? 4 : 1, 60, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
